// File: rtl/fir_arb_pkg.sv
// Shared types and widths for the FIR custom-instruction arbiter.
package fir_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int FIR_A_W = 9;
  localparam int FIR_B_W = 2;
  localparam int FIR_R_W = 32;
  localparam int CNT_W   = 5;
  localparam int MAX_REQ = 4;

endpackage

// File: rtl/fir_arb_pick.sv
// Combinational requester picker. FIR_ARB_ROUND_ROBIN_EN selects a round-robin
// search starting at ptr; otherwise the lowest set index wins and ptr is ignored.
module fir_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   j;

`ifndef FIR_ARB_ROUND_ROBIN_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FIR_ARB_ROUND_ROBIN_EN
      j = (int'(ptr) + k) % NUM_REQ;
`else
      j = k;
`endif
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fir_ci_arbiter.sv
// Shares one FIR datapath between NUM_REQ requesters; times the FIR latency with
// a counter. Picker mode is chosen by FIR_ARB_ROUND_ROBIN_EN (fixed priority when undefined).
module fir_ci_arbiter
  import fir_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 4,
  parameter int IDX_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FIR_A_W-1:0] req_dataa,
  input  logic [NUM_REQ*FIR_B_W-1:0] req_datab,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [FIR_R_W-1:0]         rsp_result,
  output logic [FIR_R_W-1:0]         rsp_resultc,
  output logic [IDX_W-1:0]           rsp_idx,
  output logic                       fir_clk_en,
  output logic [FIR_A_W-1:0]         fir_dataa,
  output logic [FIR_B_W-1:0]         fir_datab,
  input  logic [FIR_R_W-1:0]         fir_result,
  input  logic [FIR_R_W-1:0]         fir_resultc,
  output logic                       busy
);

  // Handshake: a request is accepted on the edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is only offered in IDLE.
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [FIR_A_W-1:0]   a_q, a_d;
  logic [FIR_B_W-1:0]   b_q, b_d;
  logic [FIR_R_W-1:0]   res_q, res_d;
  logic [FIR_R_W-1:0]   resc_q, resc_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]     rsp_idx_q, rsp_idx_d;
  logic                 clk_en_q, clk_en_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     pick_ptr;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;

`ifdef FIR_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  fir_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (pick_ptr),
    .grant     (pick_grant),
    .idx       (pick_idx)
  );

  assign req_ready = (state_q == IDLE && !reset) ? pick_grant : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    resc_d      = resc_q;
    rsp_valid_d = '0;
    rsp_idx_d   = rsp_idx_q;
    clk_en_d    = clk_en_q;
    busy_d      = busy_q;
`ifdef FIR_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|pick_grant) begin
          a_d      = req_dataa[int'(pick_idx)*FIR_A_W +: FIR_A_W];
          b_d      = req_datab[int'(pick_idx)*FIR_B_W +: FIR_B_W];
          grant_d  = pick_idx;
          clk_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last FIR-enabled cycle: the pipeline output belongs to our operands now.
        if (cnt_q == CNT_W'(1)) begin
          res_d       = fir_result;
          resc_d      = fir_resultc;
          rsp_idx_d   = grant_q;
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          clk_en_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef FIR_ARB_ROUND_ROBIN_EN
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      resc_q      <= '0;
      rsp_valid_q <= '0;
      rsp_idx_q   <= '0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FIR_ARB_ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      resc_q      <= resc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
`ifdef FIR_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = res_q;
  assign rsp_resultc = resc_q;
  assign rsp_idx     = rsp_idx_q;
  assign fir_clk_en  = clk_en_q;
  assign fir_dataa   = a_q;
  assign fir_datab   = b_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fir_ci_arbiter.sv
// Directed bench for fir_ci_arbiter (NUM_REQ=2, LATENCY=4) with a 4-deep
// clock-enabled FIR stand-in; grant order follows FIR_ARB_ROUND_ROBIN_EN.
module tb_fir_ci_arbiter;

  localparam int NUM_REQ = 2;
  localparam int LAT     = 4;

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*9-1:0] req_dataa;
  logic [NUM_REQ*2-1:0] req_datab;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [31:0]          rsp_result;
  logic [31:0]          rsp_resultc;
  logic [1:0]           rsp_idx;
  logic                 fir_clk_en;
  logic [8:0]           fir_dataa;
  logic [1:0]           fir_datab;
  logic [31:0]          fir_result;
  logic [31:0]          fir_resultc;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  fir_ci_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LAT), .IDX_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_dataa   (req_dataa),
    .req_datab   (req_datab),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_resultc (rsp_resultc),
    .rsp_idx     (rsp_idx),
    .fir_clk_en  (fir_clk_en),
    .fir_dataa   (fir_dataa),
    .fir_datab   (fir_datab),
    .fir_result  (fir_result),
    .fir_resultc (fir_resultc),
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIR stand-in: LAT-stage pipeline that only advances while fir_clk_en is high
  logic [10:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    if (fir_clk_en) begin
      pipe[0] <= {fir_datab, fir_dataa};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  always_comb begin
    fir_result  = {23'b0, pipe[LAT-1][8:0]} * (32'(pipe[LAT-1][10:9]) + 32'd1);
    fir_resultc = {23'b0, pipe[LAT-1][8:0]} + (32'(pipe[LAT-1][10:9]) << 16);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [8:0] a, input logic [1:0] b);
    req_dataa[9*i +: 9] = a;
    req_datab[2*i +: 2] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0] order [4];
  logic [1:0] exp_rsp;

  initial begin
`ifdef FIR_ARB_ROUND_ROBIN_EN
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd1;
`else
    order[0] = 2'd0; order[1] = 2'd0; order[2] = 2'd0; order[3] = 2'd0;
`endif
    reset     = 1'b1;
    req_valid = '0;
    req_dataa = '0;
    req_datab = '0;
    step();
    req_valid = 2'b01;
    #1;
    check("ready_in_reset", 64'(req_ready), 64'h0);
    req_valid = '0;
    step();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_clk_en", 64'(fir_clk_en), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_result", 64'(rsp_result), 64'h0);
    check("rst_resultc", 64'(rsp_resultc), 64'h0);
    check("rst_idx", 64'(rsp_idx), 64'h0);
    check("rst_dataa", 64'(fir_dataa), 64'h0);
    check("rst_datab", 64'(fir_datab), 64'h0);

    // single request: a=0x1A5, b=2 -> result 0x4EF, resultc 0x201A5
    step();
    set_req(0, 9'h1A5, 2'd2);
    req_valid = 2'b01;
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) req_valid = '0;
      check($sformatf("single_en_%0d", k), 64'(fir_clk_en), (k <= 5) ? 64'h1 : 64'h0);
      check($sformatf("single_rsp_%0d", k), 64'(rsp_valid), (k == 6) ? 64'h1 : 64'h0);
      if (k <= 5) begin
        check($sformatf("single_a_%0d", k), 64'(fir_dataa), 64'h1A5);
        check($sformatf("single_b_%0d", k), 64'(fir_datab), 64'h2);
      end
      if (k == 6) begin
        check("single_result", 64'(rsp_result), 64'h4EF);
        check("single_resultc", 64'(rsp_resultc), 64'h201A5);
        check("single_idx", 64'(rsp_idx), 64'h0);
      end
      check($sformatf("single_busy_%0d", k), 64'(busy), (k <= 6) ? 64'h1 : 64'h0);
    end

    // contention: both requesters held, responses every 7 cycles
    do_reset();
    set_req(0, 9'h010, 2'd1);
    set_req(1, 9'h0FF, 2'd3);
    req_valid = 2'b11;
    for (int n = 0; n <= 27; n++) begin
      if (n > 0) step();
      if (n >= 6 && (n - 6) % 7 == 0) begin
        exp_rsp = 2'b01 << order[(n - 6) / 7];
        check($sformatf("cont_rsp_%0d", n), 64'(rsp_valid), 64'(exp_rsp));
        check($sformatf("cont_idx_%0d", n), 64'(rsp_idx), 64'(order[(n - 6) / 7]));
        check($sformatf("cont_res_%0d", n), 64'(rsp_result),
              (order[(n - 6) / 7] == 2'd0) ? 64'h20 : 64'h3FC);
        check($sformatf("cont_resc_%0d", n), 64'(rsp_resultc),
              (order[(n - 6) / 7] == 2'd0) ? 64'h10010 : 64'h300FF);
      end else begin
        check($sformatf("cont_rsp_%0d", n), 64'(rsp_valid), 64'h0);
      end
      #1;
      if (n % 7 == 0) exp_rsp = 2'b01 << order[n / 7];
      else exp_rsp = 2'b00;
      check($sformatf("cont_ready_%0d", n), 64'(req_ready), 64'(exp_rsp));
    end
    step();
    req_valid = 2'b10;
    #1;
    check("cont_ready_r1", 64'(req_ready), 64'h2);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) req_valid = '0;
      check($sformatf("cont_r1_rsp_%0d", k), 64'(rsp_valid), (k == 6) ? 64'h2 : 64'h0);
    end
    check("cont_r1_result", 64'(rsp_result), 64'h3FC);
    check("cont_r1_idx", 64'(rsp_idx), 64'h1);

    // reset in the second WAIT cycle discards the operation
    step();
    set_req(0, 9'h033, 2'd0);
    req_valid = 2'b01;
    #1;
    check("abort_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
    step();
    check("abort_in_wait", 64'(fir_clk_en), 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_clk_en", 64'(fir_clk_en), 64'h0);
    check("abort_dataa", 64'(fir_dataa), 64'h0);
    check("abort_result", 64'(rsp_result), 64'h0);
    check("abort_resultc", 64'(rsp_resultc), 64'h0);
    check("abort_idx", 64'(rsp_idx), 64'h0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("abort_no_rsp_%0d", k), 64'(rsp_valid), 64'h0);
      step();
    end
    set_req(1, 9'h1FF, 2'd1);
    req_valid = 2'b10;
    #1;
    check("after_abort_ready", 64'(req_ready), 64'h2);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) req_valid = '0;
      check($sformatf("after_abort_rsp_%0d", k), 64'(rsp_valid), (k == 6) ? 64'h2 : 64'h0);
    end
    check("after_abort_result", 64'(rsp_result), 64'h3FE);
    check("after_abort_resultc", 64'(rsp_resultc), 64'h101FF);
    check("after_abort_idx", 64'(rsp_idx), 64'h1);

    // re-request in the RESP cycle is accepted one cycle later
    step();
    set_req(0, 9'h002, 2'd3);
    req_valid = 2'b01;
    #1;
    check("rereq_ready0", 64'(req_ready), 64'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) req_valid = '0;
    end
    check("rereq_rsp", 64'(rsp_valid), 64'h1);
    check("rereq_result", 64'(rsp_result), 64'h8);
    check("rereq_resultc", 64'(rsp_resultc), 64'h30002);
    req_valid = 2'b01;
    #1;
    check("rereq_ready_in_resp", 64'(req_ready), 64'h0);
    step();
    #1;
    check("rereq_ready_next", 64'(req_ready), 64'h1);
    check("rereq_busy_next", 64'(busy), 64'h0);
    step();
    req_valid = '0;
    for (int k = 0; k < 7; k++) step();

    // withdrawal by requester 1 while busy
    set_req(0, 9'h100, 2'd0);
    set_req(1, 9'h0AA, 2'd1);
    req_valid = 2'b01;
    #1;
    check("wd_ready0", 64'(req_ready), 64'h1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) req_valid = 2'b00;
      if (k == 2) req_valid = 2'b10;
      if (k == 4) req_valid = 2'b00;
      check($sformatf("wd_rsp_%0d", k), 64'(rsp_valid), (k == 6) ? 64'h1 : 64'h0);
      if (k == 6) check("wd_result", 64'(rsp_result), 64'h100);
      #1;
      check($sformatf("wd_ready_%0d", k), 64'(req_ready), 64'h0);
    end
    check("wd_busy", 64'(busy), 64'h0);
    check("wd_clk_en", 64'(fir_clk_en), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
